// File: rtl/sync_ff.sv
// Multi-stage flop synchronizer for a single asynchronous level signal.
module sync_ff #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk_in,
   input  logic arst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   // Shift the asynchronous input through the flop chain.
   always_ff @(posedge clk_in or negedge arst_n) begin
      if (!arst_n) begin
         chain <= '0;
      end else begin
         chain <= {chain[STAGES-2:0], d};
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/clk_mon.sv
// Clock monitor: measures period and high time of mon_clk in clk_in cycles,
// reports lock on two equal consecutive periods and flags a stopped clock.
module clk_mon #(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned TIMEOUT     = 1024
) (
   input  logic             clk_in,
   input  logic             arst_n,
   input  logic             mon_clk,
   input  logic             en,
   output logic             rise,
   output logic             fall,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             meas_valid,
   output logic             locked,
   output logic             stopped
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARM     = 2'd1,
      ST_MEASURE = 2'd2,
      ST_STOP    = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   logic             mon_sync;
   logic             mon_hist;
   logic             rise_ev_c;
   logic             fall_ev_c;
   logic             timeout_c;

   state_t           state_q,     state_d;
   logic [CNT_W-1:0] pcnt_q,      pcnt_d;
   logic [CNT_W-1:0] hcnt_q,      hcnt_d;
   logic             have_prev_q, have_prev_d;
   logic [CNT_W-1:0] period_d;
   logic [CNT_W-1:0] high_time_d;
   logic             meas_valid_d;
   logic             locked_d;
   logic             stopped_d;

   sync_ff #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk_in (clk_in),
      .arst_n (arst_n),
      .d      (mon_clk),
      .q      (mon_sync)
   );

   // History flop for edge detection on the synchronized level.
   always_ff @(posedge clk_in or negedge arst_n) begin
      if (!arst_n) begin
         mon_hist <= 1'b0;
      end else begin
         mon_hist <= mon_sync;
      end
   end

   assign rise_ev_c = mon_sync & ~mon_hist;
   assign fall_ev_c = ~mon_sync & mon_hist;
   assign timeout_c = (pcnt_q == TIMEOUT_CNT);

   // Edge strobes run regardless of enable.
   always_ff @(posedge clk_in or negedge arst_n) begin
      if (!arst_n) begin
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         rise <= rise_ev_c;
         fall <= fall_ev_c;
      end
   end

   // State register.
   always_ff @(posedge clk_in or negedge arst_n) begin
      if (!arst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state, counters and measurement results.
   always_comb begin
      state_d      = state_q;
      pcnt_d       = pcnt_q;
      hcnt_d       = hcnt_q;
      have_prev_d  = have_prev_q;
      period_d     = period;
      high_time_d  = high_time;
      meas_valid_d = 1'b0;
      locked_d     = locked;
      stopped_d    = stopped;

      if (!en) begin
         // Disable overrides everything, including a coincident rise.
         state_d     = ST_IDLE;
         pcnt_d      = CNT_ONE;
         hcnt_d      = '0;
         have_prev_d = 1'b0;
         locked_d    = 1'b0;
         stopped_d   = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               // pcnt doubles as the wait counter while armed.
               state_d = ST_ARM;
               pcnt_d  = CNT_ONE;
               hcnt_d  = '0;
            end
            ST_ARM: begin
               if (rise_ev_c) begin
                  state_d     = ST_MEASURE;
                  pcnt_d      = CNT_ONE;
                  hcnt_d      = CNT_ONE;
                  have_prev_d = 1'b0;
               end else if (timeout_c) begin
                  state_d   = ST_STOP;
                  stopped_d = 1'b1;
                  locked_d  = 1'b0;
               end else begin
                  pcnt_d = pcnt_q + CNT_ONE;
               end
            end
            ST_MEASURE: begin
               if (rise_ev_c) begin
                  period_d     = pcnt_q;
                  high_time_d  = hcnt_q;
                  meas_valid_d = 1'b1;
                  locked_d     = have_prev_q && (pcnt_q == period);
                  have_prev_d  = 1'b1;
                  pcnt_d       = CNT_ONE;
                  hcnt_d       = CNT_ONE;
               end else if (timeout_c) begin
                  state_d   = ST_STOP;
                  stopped_d = 1'b1;
                  locked_d  = 1'b0;
               end else begin
                  pcnt_d = pcnt_q + CNT_ONE;
                  hcnt_d = hcnt_q + CNT_W'(mon_sync);
               end
            end
            ST_STOP: begin
               if (rise_ev_c) begin
                  state_d     = ST_MEASURE;
                  stopped_d   = 1'b0;
                  pcnt_d      = CNT_ONE;
                  hcnt_d      = CNT_ONE;
                  have_prev_d = 1'b0;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Counter and result registers.
   always_ff @(posedge clk_in or negedge arst_n) begin
      if (!arst_n) begin
         pcnt_q      <= '0;
         hcnt_q      <= '0;
         have_prev_q <= 1'b0;
         period      <= '0;
         high_time   <= '0;
         meas_valid  <= 1'b0;
         locked      <= 1'b0;
         stopped     <= 1'b0;
      end else begin
         pcnt_q      <= pcnt_d;
         hcnt_q      <= hcnt_d;
         have_prev_q <= have_prev_d;
         period      <= period_d;
         high_time   <= high_time_d;
         meas_valid  <= meas_valid_d;
         locked      <= locked_d;
         stopped     <= stopped_d;
      end
   end

endmodule

// File: doc/clk_mon.md
CLK_MON -- requirements
Module: clk_mon

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of period/high-time counters.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, minimum 2: synchronizer depth for mon_clk.
REQ-003 SHALL have parameter TIMEOUT, default 1024: clk_in cycles without a mon_clk rise before stop is declared; 2 <= TIMEOUT <= 2^CNT_W-1.
REQ-004 SHALL have port clk_in  input  1  single reference clock; all logic on its rising edge.
REQ-005 SHALL have port arst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port mon_clk  input  1  monitored clock (e.g. a divided clock), asynchronous to clk_in.
REQ-007 SHALL have port en  input  1  measurement enable, synchronous to clk_in.
REQ-008 SHALL have port rise  output  1  one-cycle strobe per synchronized mon_clk rising edge.
REQ-009 SHALL have port fall  output  1  one-cycle strobe per synchronized mon_clk falling edge.
REQ-010 SHALL have port period  output  CNT_W  clk_in cycles between the last two measured rises.
REQ-011 SHALL have port high_time  output  CNT_W  clk_in cycles mon_clk was high within that period.
REQ-012 SHALL have port meas_valid  output  1  one-cycle pulse when period/high_time update.
REQ-013 SHALL have port locked  output  1  two consecutive equal periods measured.
REQ-014 SHALL have port stopped  output  1  no rise seen for TIMEOUT cycles.

Function
REQ-015 mon_clk SHALL pass a SYNC_STAGES flop chain, then one history flop; internal edge event = synced & ~history (rise), ~synced & history (fall).
REQ-016 rise/fall SHALL be registered, asserted exactly SYNC_STAGES+1 clk_in edges after mon_clk transition, independent of en.
REQ-017 FSM states SHALL be IDLE, ARM, MEASURE, STOP.
REQ-018 Any state with en=0 -> IDLE; IDLE with en=1 -> ARM next cycle.
REQ-019 ARM: rise event -> MEASURE, period counter and high counter loaded with 1, no meas_valid.
REQ-020 MEASURE: period counter +1 per cycle; high counter +1 per cycle with synced mon_clk high.
REQ-021 MEASURE rise event: period <= period counter, high_time <= high counter, meas_valid=1 (same cycle as rise), counters reload 1; mon_clk of N cycles yields period=N.
REQ-022 ARM/MEASURE: waiting counter reaching TIMEOUT with no rise -> STOP, stopped=1, locked=0, same edge.
REQ-023 STOP: rise event -> MEASURE, stopped=0, counters reload 1, no meas_valid.
REQ-024 locked SHALL set on meas_valid when captured period equals previous captured period and the previous capture occurred since last entry to MEASURE; SHALL clear on unequal capture, STOP entry, or IDLE.
REQ-025 Counters SHALL never wrap (guaranteed by REQ-003); TIMEOUT check takes priority only when no rise in same cycle.
REQ-026 period/high_time SHALL hold last values in IDLE, ARM, STOP.
REQ-027 en falling in the cycle of a rise event: IDLE wins, no meas_valid.

Reset
REQ-028 arst_n low SHALL immediately clear synchronizer, history, counters, FSM (IDLE), and all outputs to 0.
REQ-029 Reset release SHALL need no mon_clk activity; first valid edge event no earlier than SYNC_STAGES+1 edges after release.

Structure
REQ-030 FSM encoding and constants SHALL stay local; no shared package required.
REQ-031 Synchronizer SHALL be a separate sub-module sync_ff (parameter STAGES, async active-low reset, clk_in/arst_n naming), reusable elsewhere.

Verification (CNT_W=16, SYNC_STAGES=2, TIMEOUT=64)
REQ-032 mon_clk = clk_in/8 (4 high, 4 low), en=1 -> first measurement period=8, high_time=4; next meas_valid -> locked=1.
REQ-033 Switch mon_clk to period 10, high 3 -> meas_valid period=10, high_time=3, locked=0; following capture -> locked=1.
REQ-034 Hold mon_clk low -> stopped=1, locked=0 exactly 64 cycles after last rise event; restart -> stopped=0 at first rise, no meas_valid until second rise.
REQ-035 Single mon_clk rise -> rise strobe one cycle wide, 3 clk_in edges later; fall likewise.
REQ-036 en=0 mid-MEASURE -> IDLE, locked=0, period/high_time retained, no meas_valid; arst_n low mid-operation -> all outputs 0 without clk_in edge.
